wdata_issue_sched: RTL and testbench

- Sequences the bank-level write-data FIFO onto the DRAM DQ bus.
- For every write command issued to the DRAM, waits the write latency WL, then pops a burst of BL beats from the FIFO and drives them, registered, with an output-enable.
- Sits between the command scheduler (source of wr_cmd_issue) and the write-data FIFO's read port.
- Flags timing violations (overlapping bursts) and data underruns.

---
 rtl/wdata_pkg.sv | 19 +
 rtl/wl_delay_line.sv | 29 ++
 rtl/wdata_issue_sched.sv | 108 ++++++++++
 tb/tb_wdata_issue_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wdata_pkg.sv
// Shared types and constants for the write-data issue scheduler.
// Beat width follows the write-data FIFO width.
`ifndef WDATA_FIFO_WIDTH
`define WDATA_FIFO_WIDTH 128
`endif

package wdata_pkg;

  localparam int unsigned DATA_W     = `WDATA_FIFO_WIDTH;
  localparam int unsigned WL_DEFAULT = 4;
  localparam int unsigned BL_DEFAULT = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wsched_state_t;

endpackage

// File: rtl/wl_delay_line.sv
// Write-latency delay line: delays each command pulse by DEPTH cycles.
// Also exposes whether any command is still in flight.
module wl_delay_line #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic any_pending
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout        = sr_q[DEPTH-1];
  assign any_pending = |sr_q;

endmodule

// File: rtl/wdata_issue_sched.sv
// Pops one BL-beat burst from the write-data FIFO WL cycles after each
// write command and drives it registered onto the DQ bus.
module wdata_issue_sched
  import wdata_pkg::*;
#(
  parameter int unsigned DATA_W = wdata_pkg::DATA_W,
  parameter int unsigned WL     = WL_DEFAULT,
  parameter int unsigned BL     = BL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_cmd_issue,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_ren,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              dq_last,
  output logic              busy,
  output logic              overlap_err,
  output logic              underrun_err,
  input  logic              err_clr
);

  wsched_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_pulse;
  logic             any_pending;
  logic             last_pop;
  logic             overlap_set;
  logic             underrun_set;

  wl_delay_line #(
    .DEPTH (WL)
  ) u_delay (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (wr_cmd_issue),
    .dout        (start_pulse),
    .any_pending (any_pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen mid-burst is dropped and only flagged.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fifo_ren    = 1'b0;
    last_pop    = 1'b0;
    overlap_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          fifo_ren = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = BURST;
        end
      end
      BURST: begin
        fifo_ren    = 1'b1;
        overlap_set = start_pulse;
        if (cnt_q == CNT_W'(BL - 1)) begin
          last_pop = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign underrun_set = fifo_ren & fifo_empty;
  assign busy         = (state_q == BURST) | any_pending;

  // Empty-FIFO beats go out as zero so the burst length is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_out       <= '0;
      dq_oe        <= 1'b0;
      dq_last      <= 1'b0;
      overlap_err  <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      if (fifo_ren) begin
        dq_out  <= fifo_empty ? '0 : fifo_data;
        dq_oe   <= 1'b1;
        dq_last <= last_pop;
      end else begin
        dq_oe   <= 1'b0;
        dq_last <= 1'b0;
      end
      overlap_err  <= overlap_set  | (overlap_err  & ~err_clr);
      underrun_err <= underrun_set | (underrun_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_wdata_issue_sched.sv
// Directed bench for wdata_issue_sched with a fall-through FIFO model.
// Cycle c of each scenario is the clock period whose inputs are set at its negedge.
module tb_wdata_issue_sched;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_cmd_issue = 1'b0;
  logic          err_clr = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty, fifo_ren, dq_oe, dq_last, busy, overlap_err, underrun_err;
  logic [DW-1:0] fifo_data, dq_out;
  logic [DW-1:0] mem [64];
  logic [5:0]    rd_ptr;
  logic [5:0]    wr_ptr = '0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  wdata_issue_sched #(.DATA_W(DW), .WL(4), .BL(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_cmd_issue (wr_cmd_issue),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_ren     (fifo_ren),
    .dq_out       (dq_out),
    .dq_oe        (dq_oe),
    .dq_last      (dq_last),
    .busy         (busy),
    .overlap_err  (overlap_err),
    .underrun_err (underrun_err),
    .err_clr      (err_clr)
  );

  // FIFO model: shares rst_n with the DUT; reset/flush empties it.
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rd_ptr <= wr_ptr;
    else if (flush)                   rd_ptr <= wr_ptr;
    else if (fifo_ren && !fifo_empty) rd_ptr <= rd_ptr + 6'd1;
  end

  task automatic push(input int v);
    mem[wr_ptr] = DW'(v);
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", fifo_ren); end
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", dq_oe); end
    checks++; if (dq_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", dq_last); end
    checks++; if (dq_out !== '0) begin errors++; $display("FAIL reset_dq got %h exp 0", dq_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({overlap_err, underrun_err} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {overlap_err, underrun_err}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_flush();
  endtask

  task automatic test_single_write();
    bit eren, eoe, elast, ebusy;
    for (int i = 1; i <= 8; i++) push(i);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      wr_cmd_issue = (c == 0);
      #1;
      eren = (c >= 4 && c <= 11); eoe = (c >= 5 && c <= 12);
      elast = (c == 12); ebusy = (c >= 1 && c <= 11);
      checks++; if (fifo_ren !== eren) begin errors++; $display("FAIL single_ren c=%0d got %b exp %b", c, fifo_ren, eren); end
      checks++; if (dq_oe !== eoe) begin errors++; $display("FAIL single_oe c=%0d got %b exp %b", c, dq_oe, eoe); end
      checks++; if (dq_last !== elast) begin errors++; $display("FAIL single_last c=%0d got %b exp %b", c, dq_last, elast); end
      checks++; if (busy !== ebusy) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, ebusy); end
      if (eoe) begin
        checks++; if (dq_out !== DW'(c - 4)) begin errors++; $display("FAIL single_dq c=%0d got %h exp %h", c, dq_out, DW'(c - 4)); end
      end
    end
    checks++; if ({overlap_err, underrun_err} !== 2'b00) begin errors++; $display("FAIL single_err got %b exp 00", {overlap_err, underrun_err}); end
  endtask

  task automatic test_back_to_back();
    bit eren, eoe, elast, ebusy;
    do_flush();
    for (int i = 1; i <= 16; i++) push(32'h10 + i);
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      wr_cmd_issue = (c == 0 || c == 8);
      #1;
      eren = (c >= 4 && c <= 19); eoe = (c >= 5 && c <= 20);
      elast = (c == 12 || c == 20); ebusy = (c >= 1 && c <= 19);
      checks++; if (fifo_ren !== eren) begin errors++; $display("FAIL b2b_ren c=%0d got %b exp %b", c, fifo_ren, eren); end
      checks++; if (dq_oe !== eoe) begin errors++; $display("FAIL b2b_oe c=%0d got %b exp %b", c, dq_oe, eoe); end
      checks++; if (dq_last !== elast) begin errors++; $display("FAIL b2b_last c=%0d got %b exp %b", c, dq_last, elast); end
      checks++; if (busy !== ebusy) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, ebusy); end
      if (eoe) begin
        checks++; if (dq_out !== DW'(32'h10 + c - 4)) begin errors++; $display("FAIL b2b_dq c=%0d got %h exp %h", c, dq_out, DW'(32'h10 + c - 4)); end
      end
    end
    checks++; if ({overlap_err, underrun_err} !== 2'b00) begin errors++; $display("FAIL b2b_err got %b exp 00", {overlap_err, underrun_err}); end
  endtask

  task automatic test_overlap();
    bit eren, eoe, ebusy, eovl;
    do_flush();
    for (int i = 1; i <= 8; i++) push(32'h20 + i);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      wr_cmd_issue = (c == 0 || c == 4);
      #1;
      eren = (c >= 4 && c <= 11); eoe = (c >= 5 && c <= 12);
      ebusy = (c >= 1 && c <= 11); eovl = (c >= 9);
      checks++; if (fifo_ren !== eren) begin errors++; $display("FAIL ovl_ren c=%0d got %b exp %b", c, fifo_ren, eren); end
      checks++; if (dq_oe !== eoe) begin errors++; $display("FAIL ovl_oe c=%0d got %b exp %b", c, dq_oe, eoe); end
      checks++; if (busy !== ebusy) begin errors++; $display("FAIL ovl_busy c=%0d got %b exp %b", c, busy, ebusy); end
      checks++; if (overlap_err !== eovl) begin errors++; $display("FAIL ovl_flag c=%0d got %b exp %b", c, overlap_err, eovl); end
      if (eoe) begin
        checks++; if (dq_out !== DW'(32'h20 + c - 4)) begin errors++; $display("FAIL ovl_dq c=%0d got %h exp %h", c, dq_out, DW'(32'h20 + c - 4)); end
      end
    end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    checks++; if (overlap_err !== 1'b0) begin errors++; $display("FAIL ovl_clr got %b exp 0", overlap_err); end
  endtask

  task automatic test_underrun();
    bit eoe, elast, eund;
    logic [DW-1:0] edq;
    do_flush();
    for (int i = 1; i <= 5; i++) push(32'h30 + i);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      wr_cmd_issue = (c == 0);
      err_clr = (c == 10 || c == 14);
      #1;
      eoe = (c >= 5 && c <= 12); elast = (c == 12);
      eund = (c >= 10 && c <= 14);
      edq = (c <= 9) ? DW'(32'h30 + c - 4) : '0;
      checks++; if (dq_oe !== eoe) begin errors++; $display("FAIL und_oe c=%0d got %b exp %b", c, dq_oe, eoe); end
      checks++; if (dq_last !== elast) begin errors++; $display("FAIL und_last c=%0d got %b exp %b", c, dq_last, elast); end
      checks++; if (underrun_err !== eund) begin errors++; $display("FAIL und_flag c=%0d got %b exp %b", c, underrun_err, eund); end
      if (eoe) begin
        checks++; if (dq_out !== edq) begin errors++; $display("FAIL und_dq c=%0d got %h exp %h", c, dq_out, edq); end
      end
    end
    err_clr = 1'b0;
    checks++; if (overlap_err !== 1'b0) begin errors++; $display("FAIL und_ovl got %b exp 0", overlap_err); end
  endtask

  task automatic test_reset_mid_burst();
    bit eren, eoe, elast;
    do_flush();
    for (int i = 1; i <= 8; i++) push(32'h40 + i);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wr_cmd_issue = (c == 0);
      #1;
      eoe = (c >= 5);
      checks++; if (dq_oe !== eoe) begin errors++; $display("FAIL rmb_oe c=%0d got %b exp %b", c, dq_oe, eoe); end
      if (eoe) begin
        checks++; if (dq_out !== DW'(32'h40 + c - 4)) begin errors++; $display("FAIL rmb_dq c=%0d got %h exp %h", c, dq_out, DW'(32'h40 + c - 4)); end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL rmb_async_oe got %b exp 0", dq_oe); end
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL rmb_async_ren got %b exp 0", fifo_ren); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmb_async_busy got %b exp 0", busy); end
    checks++; if (dq_out !== '0) begin errors++; $display("FAIL rmb_async_dq got %h exp 0", dq_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) push(32'h50 + i);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      wr_cmd_issue = (c == 0);
      #1;
      eren = (c >= 4 && c <= 11); eoe = (c >= 5 && c <= 12); elast = (c == 12);
      checks++; if (fifo_ren !== eren) begin errors++; $display("FAIL rmb2_ren c=%0d got %b exp %b", c, fifo_ren, eren); end
      checks++; if (dq_oe !== eoe) begin errors++; $display("FAIL rmb2_oe c=%0d got %b exp %b", c, dq_oe, eoe); end
      checks++; if (dq_last !== elast) begin errors++; $display("FAIL rmb2_last c=%0d got %b exp %b", c, dq_last, elast); end
      if (eoe) begin
        checks++; if (dq_out !== DW'(32'h50 + c - 4)) begin errors++; $display("FAIL rmb2_dq c=%0d got %h exp %h", c, dq_out, DW'(32'h50 + c - 4)); end
      end
    end
    checks++; if ({overlap_err, underrun_err} !== 2'b00) begin errors++; $display("FAIL rmb2_err got %b exp 00", {overlap_err, underrun_err}); end
  endtask

  task automatic test_pipelined_refill();
    bit eoe, elast, ebusy;
    do_flush();
    for (int i = 1; i <= 8; i++) push(32'h60 + i);
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      wr_cmd_issue = (c == 0 || c == 8);
      if (c >= 2 && c <= 9) push(32'h67 + c);
      #1;
      eoe = (c >= 5 && c <= 20); elast = (c == 12 || c == 20);
      ebusy = (c >= 1 && c <= 19);
      checks++; if (dq_oe !== eoe) begin errors++; $display("FAIL pipe_oe c=%0d got %b exp %b", c, dq_oe, eoe); end
      checks++; if (dq_last !== elast) begin errors++; $display("FAIL pipe_last c=%0d got %b exp %b", c, dq_last, elast); end
      checks++; if (busy !== ebusy) begin errors++; $display("FAIL pipe_busy c=%0d got %b exp %b", c, busy, ebusy); end
      if (eoe) begin
        checks++; if (dq_out !== DW'(32'h60 + c - 4)) begin errors++; $display("FAIL pipe_dq c=%0d got %h exp %h", c, dq_out, DW'(32'h60 + c - 4)); end
      end
    end
    checks++; if ({overlap_err, underrun_err} !== 2'b00) begin errors++; $display("FAIL pipe_err got %b exp 00", {overlap_err, underrun_err}); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_overlap();
    test_underrun();
    test_reset_mid_burst();
    test_pipelined_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
